// File: rtl/pc_gen_ras_pkg.sv
// Shared control encodings and default vectors for the fetch PC generator.
package ctrl_encode_def;

  // jump field
  localparam logic [1:0] JMP_NONE = 2'd0;
  localparam logic [1:0] JMP_IMM  = 2'd1;
  localparam logic [1:0] JMP_REG  = 2'd2;
  localparam logic [1:0] JMP_RSVD = 2'd3;

  // branch field
  localparam logic [1:0] BR_NONE  = 2'd0;
  localparam logic [1:0] BR_Z     = 2'd1;
  localparam logic [1:0] BR_NZ    = 2'd2;
  localparam logic [1:0] BR_RSVD  = 2'd3;

  // next-PC source select
  typedef enum logic [2:0] {
    NPC_PLUS4    = 3'd0,
    NPC_BRANCH   = 3'd1,
    NPC_JUMP_IMM = 3'd2,
    NPC_JUMP_REG = 3'd3,
    NPC_CALL     = 3'd4,
    NPC_RET      = 3'd5,
    NPC_EXC      = 3'd6
  } npc_sel_e;

  // default vectors
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;

endpackage

// File: rtl/pc_gen_ras_ras_stack.sv
// Return-address stack: circular buffer, push on full overwrites the oldest entry.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [XLEN-1:0]            push_data,
  output logic [XLEN-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [RAS_DEPTH-1:0][XLEN-1:0] r_mem;
  logic [PW-1:0]                  r_ptr;   // next free slot; top lives at r_ptr-1
  logic [CW-1:0]                  r_cnt;
  logic [PW-1:0]                  w_top_idx;

  assign w_top_idx = r_ptr - PW'(1);
  assign top       = r_mem[w_top_idx];
  assign count     = r_cnt;
  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == DEPTH_C);

  // per-entry storage; contents need no reset
  for (genvar i = 0; i < RAS_DEPTH; i++) begin : g_ent
    always_ff @(posedge clk) begin
      if (push && (r_ptr == PW'(i))) r_mem[i] <= push_data;
    end
  end

  // pointer and occupancy; count saturates while the pointer keeps wrapping
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + PW'(1);
      if (r_cnt != DEPTH_C) r_cnt <= r_cnt + CW'(1);
    end else if (pop && (r_cnt != '0)) begin
      r_ptr <= r_ptr - PW'(1);
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch PC generator: PC register, fetch handshake and prioritised next-PC mux.
module pc_gen_ras
  import ctrl_encode_def::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(DEF_EXC_VECTOR),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 jump,
  input  logic [1:0]                 branch,
  input  logic                       zero,
  input  logic                       call,
  input  logic                       ret,
  input  logic [XLEN-1:0]            imm,
  input  logic [XLEN-1:0]            addr,
  input  logic                       exc,
  input  logic                       if_ready,
  output logic                       if_valid,
  output logic [XLEN-1:0]            pc,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_empty,
  output logic                       ras_full
);
  logic [XLEN-1:0] r_pc;
  logic            r_vld;
  logic            w_fire;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_br_off;
  logic [XLEN-1:0] w_npc;
  logic            w_taken;
  logic [XLEN-1:0] w_ras_top;
  logic            w_push;
  logic            w_pop;
  logic            w_clear;
  npc_sel_e        w_sel;

  assign w_fire   = r_vld & if_ready;
  assign w_pc4    = r_pc + XLEN'(4);
  assign w_br_off = {{(XLEN-18){imm[15]}}, imm[15:0], 2'b00};
  assign w_taken  = ((branch == BR_Z) & zero) | ((branch == BR_NZ) & ~zero);

  // source select in priority order; exception wins regardless of handshake
  always_comb begin
    w_sel = NPC_PLUS4;
    if (exc)                                     w_sel = NPC_EXC;
    else if ((jump == JMP_REG) & ret & ~ras_empty) w_sel = NPC_RET;
    else if (jump == JMP_REG)                    w_sel = NPC_JUMP_REG;
    else if (jump == JMP_IMM)                    w_sel = call ? NPC_CALL : NPC_JUMP_IMM;
    else if (w_taken)                            w_sel = NPC_BRANCH;
  end

  // target for the selected source
  always_comb begin
    w_npc = w_pc4;
    case (w_sel)
      NPC_EXC:                w_npc = EXC_VECTOR;
      NPC_RET:                w_npc = w_ras_top;
      NPC_JUMP_REG:           w_npc = addr;
      NPC_JUMP_IMM, NPC_CALL: w_npc = {w_pc4[XLEN-1:28], imm[25:0], 2'b00};
      NPC_BRANCH:             w_npc = w_pc4 + w_br_off;
      default:                w_npc = w_pc4;
    endcase
  end

  // RAS side effects only happen on an accepted fetch; clear follows exc
  assign w_clear = exc;
  assign w_push  = w_fire & ~exc & (w_sel == NPC_CALL);
  assign w_pop   = w_fire & ~exc & (w_sel == NPC_RET);

  ras_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .clear     (w_clear),
    .push_data (w_pc4),
    .top       (w_ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // PC register and fetch-valid flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc  <= RESET_VECTOR;
      r_vld <= 1'b0;
    end else begin
      r_vld <= 1'b1;
      if (exc)         r_pc <= EXC_VECTOR;
      else if (w_fire) r_pc <= w_npc;
    end
  end

  assign pc       = r_pc;
  assign if_valid = r_vld;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras with a queue-based scoreboard.
module tb_pc_gen_ras;
  logic        clk = 1'b0;
  logic        rst, zero, call, ret, exc, if_ready, if_valid, ras_empty, ras_full;
  logic [1:0]  jump, branch;
  logic [31:0] imm, addr, pc;
  logic [2:0]  ras_count;

  typedef struct {
    logic [31:0] pc;
    logic        vld;
    logic [2:0]  cnt;
    int          id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   vec_id = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  pc_gen_ras dut (
    .clk(clk), .rst(rst), .jump(jump), .branch(branch), .zero(zero),
    .call(call), .ret(ret), .imm(imm), .addr(addr), .exc(exc),
    .if_ready(if_ready), .if_valid(if_valid), .pc(pc),
    .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  // drive one cycle of inputs at negedge and queue the state expected after the next posedge
  task automatic stp(input logic r, input logic [1:0] j, input logic [1:0] b,
                     input logic z, input logic c, input logic rt,
                     input logic [31:0] im, input logic [31:0] ad,
                     input logic e, input logic rd,
                     input logic [31:0] xpc, input logic xv, input logic [2:0] xc);
    exp_t x;
    @(negedge clk);
    rst = r; jump = j; branch = b; zero = z; call = c; ret = rt;
    imm = im; addr = ad; exc = e; if_ready = rd;
    x.pc = xpc; x.vld = xv; x.cnt = xc; x.id = vec_id;
    vec_id++;
    q.push_back(x);
  endtask

  // monitor: after each rising edge compare DUT outputs with the oldest expectation
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        checks++;
        if (pc !== x.pc) begin
          failures++;
          $display("FAIL pc vec%0d: got %h want %h", x.id, pc, x.pc);
        end
        checks++;
        if (if_valid !== x.vld) begin
          failures++;
          $display("FAIL if_valid vec%0d: got %b want %b", x.id, if_valid, x.vld);
        end
        checks++;
        if (ras_count !== x.cnt) begin
          failures++;
          $display("FAIL ras_count vec%0d: got %0d want %0d", x.id, ras_count, x.cnt);
        end
        checks++;
        if (ras_full !== (x.cnt == 3'd4)) begin
          failures++;
          $display("FAIL ras_full vec%0d: got %b want %b", x.id, ras_full, x.cnt == 3'd4);
        end
        checks++;
        if (ras_empty !== (x.cnt == 3'd0)) begin
          failures++;
          $display("FAIL ras_empty vec%0d: got %b want %b", x.id, ras_empty, x.cnt == 3'd0);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; jump = 2'd0; branch = 2'd0; zero = 1'b0; call = 1'b0; ret = 1'b0;
    imm = '0; addr = '0; exc = 1'b0; if_ready = 1'b1;
    //   rst j  b  z  c  r  imm           addr          e  rdy  exp_pc        v  cnt
    // reset and sequential fetch
    stp(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h0,        0, 0);
    stp(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h0,        0, 0);
    stp(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h0,        1, 0);
    stp(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h4,        1, 0);
    stp(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h8,        1, 0);
    stp(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'hC,        1, 0);
    stp(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h10,       1, 0);
    // branches
    stp(1, 0, 1, 1, 0, 0, 32'hFFFF,     32'h0,        0, 1, 32'h10,       1, 0);
    stp(1, 0, 1, 0, 0, 0, 32'hFFFF,     32'h0,        0, 1, 32'h14,       1, 0);
    stp(1, 0, 2, 1, 0, 0, 32'h1,        32'h0,        0, 1, 32'h18,       1, 0);
    stp(1, 0, 2, 0, 0, 0, 32'h1,        32'h0,        0, 1, 32'h20,       1, 0);
    // call / return pair
    stp(1, 1, 0, 0, 1, 0, 32'h40,       32'h0,        0, 1, 32'h100,      1, 1);
    stp(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h104,      1, 1);
    stp(1, 2, 0, 0, 0, 1, 32'h0,        32'hDEAD,     0, 1, 32'h24,       1, 0);
    // call without jump ignored; reserved jump encoding is sequential
    stp(1, 0, 0, 0, 1, 0, 32'h40,       32'h0,        0, 1, 32'h28,       1, 0);
    stp(1, 3, 0, 0, 0, 0, 32'h40,       32'h9000,     0, 1, 32'h2C,       1, 0);
    // five calls into a 4-deep RAS, then five rets
    stp(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h0,        0, 0);
    stp(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h0,        1, 0);
    stp(1, 1, 0, 0, 1, 0, 32'h40,       32'h0,        0, 1, 32'h100,      1, 1);
    stp(1, 1, 0, 0, 1, 0, 32'h80,       32'h0,        0, 1, 32'h200,      1, 2);
    stp(1, 1, 0, 0, 1, 0, 32'hC0,       32'h0,        0, 1, 32'h300,      1, 3);
    stp(1, 1, 0, 0, 1, 0, 32'h100,      32'h0,        0, 1, 32'h400,      1, 4);
    stp(1, 1, 0, 0, 1, 0, 32'h140,      32'h0,        0, 1, 32'h500,      1, 4);
    stp(1, 2, 0, 0, 0, 1, 32'h0,        32'hBAD0,     0, 1, 32'h404,      1, 3);
    stp(1, 2, 0, 0, 0, 1, 32'h0,        32'hBAD0,     0, 1, 32'h304,      1, 2);
    stp(1, 2, 0, 0, 0, 1, 32'h0,        32'hBAD0,     0, 1, 32'h204,      1, 1);
    stp(1, 2, 0, 0, 0, 1, 32'h0,        32'hBAD0,     0, 1, 32'h104,      1, 0);
    stp(1, 2, 0, 0, 0, 1, 32'h0,        32'h500,      0, 1, 32'h500,      1, 0);
    stp(1, 2, 0, 0, 0, 0, 32'h0,        32'h1000,     0, 1, 32'h1000,     1, 0);
    // stall holds the call, then it takes effect once
    stp(1, 1, 0, 0, 1, 0, 32'h40,       32'h0,        0, 0, 32'h1000,     1, 0);
    stp(1, 1, 0, 0, 1, 0, 32'h40,       32'h0,        0, 0, 32'h1000,     1, 0);
    stp(1, 1, 0, 0, 1, 0, 32'h40,       32'h0,        0, 0, 32'h1000,     1, 0);
    stp(1, 1, 0, 0, 1, 0, 32'h40,       32'h0,        0, 1, 32'h100,      1, 1);
    stp(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h104,      1, 1);
    stp(1, 1, 0, 0, 1, 0, 32'h80,       32'h0,        0, 1, 32'h200,      1, 2);
    // exception while stalled clears RAS, then reset mid-stall
    stp(1, 2, 0, 0, 0, 1, 32'h0,        32'h0,        1, 0, 32'h180,      1, 0);
    stp(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h180,      1, 0);
    stp(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0);
    stp(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 0);
    stp(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h4,        1, 0);
    // exception on the first post-reset edge (if_valid still 0)
    stp(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h0,        0, 0);
    stp(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h180,      1, 0);
    // branch wrap below zero and jump keeping upper pc4 bits
    stp(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h0,        0, 0);
    stp(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h0,        1, 0);
    stp(1, 0, 1, 1, 0, 0, 32'h8000,     32'h0,        0, 1, 32'hFFFE0004, 1, 0);
    stp(1, 1, 0, 0, 0, 0, 32'h10,       32'h0,        0, 1, 32'hF0000040, 1, 0);
    stp(1, 1, 0, 0, 1, 0, 32'h3FFFFFF,  32'h0,        0, 1, 32'hFFFFFFFC, 1, 1);
    stp(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h0,        1, 1);
    stp(1, 2, 0, 0, 0, 1, 32'h0,        32'h0,        0, 1, 32'hF0000044, 1, 0);
    stp(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h180,      1, 0);
    // drain: give the monitor a bounded number of cycles
    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    done = 1'b1;
    $finish;
  end

endmodule
